// File: rtl/weight_bank.sv
// weight_bank: multi-lane weight store with LFSR random fill.
// Each access moves LANES consecutive words starting at Address; lanes that
// fall at or beyond DEPTH are dropped on write and read back as zero.
module weight_bank #(
    parameter int unsigned DW    = 10,
    parameter int unsigned DEPTH = 65,
    parameter int unsigned LANES = 10,
    parameter int unsigned AW    = 7,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic                Clock,
    input  logic                Rst,
    input  logic                InitReq,
    output logic                Busy,
    output logic                InitDone,
    input  logic [AW-1:0]       Address,
    input  logic                WE,
    input  logic                RE,
    input  logic [LANES*DW-1:0] D,
    output logic [LANES*DW-1:0] Q,
    output logic                QValid,
    output logic                AddrErr
);

    localparam int unsigned   IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [15:0]   SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LANES_W  = (AW+1)'(LANES);
    localparam logic [IW-1:0] LAST     = IW'(DEPTH - 1);

    typedef enum logic {IDLE, INIT} state_t;

    state_t              state;
    logic [IW-1:0]       cnt;
    logic [15:0]         lfsr;
    logic                lfsr_fb;
    logic [DW-1:0]       mem [DEPTH];

    logic [IW-1:0]       lane_idx [LANES];
    logic [LANES-1:0]    lane_ok;
    logic [LANES*DW-1:0] rd_data;
    logic                out_of_range;
    logic                fill_we;
    logic                acc;
    logic                acc_we;

    assign lfsr_fb      = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign out_of_range = ({1'b0, Address} + LANES_W) > DEPTH_W;
    // Nothing is written on a reset edge, so an aborted fill leaves earlier words intact.
    assign fill_we      = Rst && (state == INIT);
    assign acc          = Rst && (state == IDLE) && !InitReq && (WE || RE);
    assign acc_we       = acc && WE;

    // Per-lane address decode and read-data gather (out-of-range lanes read 0).
    always_comb begin
        logic [AW:0] lane_addr;
        lane_addr = '0;
        lane_ok   = '0;
        rd_data   = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_addr   = {1'b0, Address} + (AW+1)'(i);
            lane_idx[i] = lane_addr[IW-1:0];
            lane_ok[i]  = lane_addr < DEPTH_W;
            if (lane_ok[i]) begin
                rd_data[i*DW +: DW] = mem[lane_idx[i]];
            end
        end
    end

    // Storage array: fill writes from the LFSR, otherwise in-range lane writes.
    always_ff @(posedge Clock) begin
        if (fill_we) begin
            mem[cnt] <= lfsr[DW-1:0];
        end else if (acc_we) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (lane_ok[i]) begin
                    mem[lane_idx[i]] <= D[i*DW +: DW];
                end
            end
        end
    end

    // Control FSM: fill sequencing, LFSR stepping and registered access outputs.
    always_ff @(posedge Clock) begin
        if (!Rst) begin
            state    <= IDLE;
            cnt      <= '0;
            lfsr     <= SEED_EFF;
            Q        <= '0;
            QValid   <= 1'b0;
            Busy     <= 1'b0;
            InitDone <= 1'b0;
            AddrErr  <= 1'b0;
        end else begin
            QValid   <= 1'b0;
            InitDone <= 1'b0;
            AddrErr  <= 1'b0;
            case (state)
                IDLE: begin
                    if (InitReq) begin
                        state <= INIT;
                        cnt   <= '0;
                        Busy  <= 1'b1;
                    end else if (WE || RE) begin
                        AddrErr <= out_of_range;
                        if (!WE) begin
                            Q      <= rd_data;
                            QValid <= 1'b1;
                        end
                    end
                end
                INIT: begin
                    lfsr <= {lfsr[14:0], lfsr_fb};
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state    <= IDLE;
                        Busy     <= 1'b0;
                        InitDone <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_bank.sv
// tb_weight_bank: directed and random checks of weight_bank against an
// array-based reference model.
module tb_weight_bank;

    localparam int          DW    = 10;
    localparam int          DEPTH = 65;
    localparam int          LANES = 10;
    localparam int          AW    = 7;
    localparam logic [15:0] SEED  = 16'hACE1;
    localparam int          QW    = LANES * DW;

    logic          Clock   = 1'b0;
    logic          Rst     = 1'b0;
    logic          InitReq = 1'b0;
    logic          WE      = 1'b0;
    logic          RE      = 1'b0;
    logic [AW-1:0] Address = '0;
    logic [QW-1:0] D       = '0;
    logic          Busy;
    logic          InitDone;
    logic [QW-1:0] Q;
    logic          QValid;
    logic          AddrErr;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mdl [DEPTH];
    logic [15:0]   mdl_lfsr;
    logic [QW-1:0] exp_q;

    weight_bank #(
        .DW(DW), .DEPTH(DEPTH), .LANES(LANES), .AW(AW), .SEED(SEED)
    ) dut (
        .Clock(Clock), .Rst(Rst), .InitReq(InitReq), .Busy(Busy),
        .InitDone(InitDone), .Address(Address), .WE(WE), .RE(RE),
        .D(D), .Q(Q), .QValid(QValid), .AddrErr(AddrErr)
    );

    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [QW-1:0] obs, input logic [QW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // x^16+x^14+x^13+x^11+1, shifted left, feedback into bit 0
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Model of n fill writes starting at word 0.
    task automatic model_fill(input int n);
        for (int c = 0; c < n; c++) begin
            mdl[c]   = mdl_lfsr[DW-1:0];
            mdl_lfsr = lfsr_step(mdl_lfsr);
        end
    endtask

    // One access cycle, with model update and output checks.
    task automatic access(input bit we, input bit re, input int addr,
                          input logic [QW-1:0] d, input string tag);
        bit exp_err;
        bit exp_qv;
        WE = we; RE = re; Address = AW'(addr); D = d;
        step();
        WE = 1'b0; RE = 1'b0;
        exp_err = (we || re) && (addr + LANES > DEPTH);
        exp_qv  = 1'b0;
        if (we) begin
            for (int i = 0; i < LANES; i++)
                if (addr + i < DEPTH) mdl[addr + i] = d[i*DW +: DW];
        end else if (re) begin
            exp_qv = 1'b1;
            for (int i = 0; i < LANES; i++)
                exp_q[i*DW +: DW] = (addr + i < DEPTH) ? mdl[addr + i] : '0;
        end
        check({tag, "_q"}, Q, exp_q);
        check({tag, "_qvalid"}, QV_ext(QValid), QV_ext(exp_qv));
        check({tag, "_addrerr"}, QV_ext(AddrErr), QV_ext(exp_err));
    endtask

    function automatic logic [QW-1:0] QV_ext(input logic b);
        return {{(QW-1){1'b0}}, b};
    endfunction

    // Waits (bounded) for a running fill to end; expects DEPTH busy cycles and one done pulse.
    task automatic wait_fill(input string tag);
        int n;
        int dn;
        n  = 0;
        dn = 0;
        while (Busy === 1'b1 && n < 4 * DEPTH) begin
            n++;
            step();
            if (InitDone === 1'b1) dn++;
        end
        step();
        if (InitDone === 1'b1) dn++;
        check({tag, "_busy_cycles"}, QW'(n), QW'(DEPTH));
        check({tag, "_done_pulses"}, QW'(dn), QW'(1));
    endtask

    function automatic logic [QW-1:0] rand_d();
        logic [QW-1:0] d;
        for (int i = 0; i < LANES; i++) d[i*DW +: DW] = DW'($urandom);
        return d;
    endfunction

    initial begin
        logic [QW-1:0] d;
        int            addr;
        int            op;

        // reset
        Rst = 1'b0;
        step();
        step();
        exp_q = '0;
        check("rst_q", Q, '0);
        check("rst_qvalid", QV_ext(QValid), '0);
        check("rst_busy", QV_ext(Busy), '0);
        check("rst_initdone", QV_ext(InitDone), '0);
        check("rst_addrerr", QV_ext(AddrErr), '0);
        mdl_lfsr = SEED;
        Rst = 1'b1;

        // first random fill
        InitReq = 1'b1;
        step();
        InitReq = 1'b0;
        check("fill1_busy_start", QV_ext(Busy), QV_ext(1'b1));
        wait_fill("fill1");
        model_fill(DEPTH);
        for (int a = 0; a <= 60; a += 10) access(0, 1, a, '0, "fill1_rd");

        // directed lane write/read
        for (int i = 0; i < LANES; i++) d[i*DW +: DW] = DW'(i + 1);
        access(1, 0, 20, d, "wr20");
        access(0, 1, 20, '0, "rd20");

        // write straddling the end of the array
        for (int i = 0; i < LANES; i++) d[i*DW +: DW] = DW'(100 + i);
        access(1, 0, 60, d, "wr60");
        access(0, 1, 60, '0, "rd60");

        // WE and RE together: write lands, read dropped
        access(1, 1, 0, rand_d(), "wrrd0");
        access(0, 1, 0, '0, "rd0");

        // InitReq with WE: access dropped, fill starts
        InitReq = 1'b1; WE = 1'b1; Address = AW'(60); D = rand_d();
        step();
        InitReq = 1'b0; WE = 1'b0;
        check("initwe_busy", QV_ext(Busy), QV_ext(1'b1));
        check("initwe_addrerr", QV_ext(AddrErr), '0);
        check("initwe_qvalid", QV_ext(QValid), '0);
        check("initwe_q", Q, exp_q);

        // abort the fill with reset at fill cycle 30
        repeat (29) step();
        Rst = 1'b0;
        step();
        model_fill(29);
        mdl_lfsr = SEED;
        exp_q    = '0;
        check("abort_busy", QV_ext(Busy), '0);
        check("abort_q", Q, '0);
        Rst = 1'b1;
        step();
        check("abort_initdone", QV_ext(InitDone), '0);
        access(0, 1, 20, '0, "abort_rd20");
        access(0, 1, 0, '0, "abort_rd0");

        // refill restarts from SEED
        InitReq = 1'b1;
        step();
        InitReq = 1'b0;
        check("fill2_busy_start", QV_ext(Busy), QV_ext(1'b1));
        wait_fill("fill2");
        model_fill(DEPTH);
        for (int a = 0; a <= 60; a += 10) access(0, 1, a, '0, "fill2_rd");

        // random back-to-back traffic
        for (int n = 0; n < 300; n++) begin
            op   = $urandom_range(0, 3);
            addr = ($urandom_range(0, 9) == 0) ? $urandom_range(0, (1 << AW) - 1)
                                               : $urandom_range(0, DEPTH - 1);
            access(op == 0 || op == 2, op == 1 || op == 2, addr, rand_d(), "rand");
        end
        check("rand_busy", QV_ext(Busy), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
